shift_rows_unit: RTL
====================

// Module: shift_rows_unit
// PURPOSE
//  Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage for the AES datapath.
//  - Supports block widths of NB = 4, 6 or 8 columns.
//  - The direction is selected per transaction, so encrypt and decrypt rounds share one instance.
//  - A valid/ready handshake and a 2-entry skid buffer sustain 1 state/cycle under back-pressure.
//  - Sits between the SubBytes and MixColumns stages of the round pipeline.
// PARAMETERS
//  NB     4  columns in the state (4 = AES-128 block; 6, 8 = Rijndael); any other value is an elaboration error
//  TAG_W  8  width of the sideband tag (round number / key slot) carried alongside the state
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         input transaction present
//  in_ready   out  1         unit can accept a transaction this cycle
//  in_mode    in   1         0 = forward ShiftRows, 1 = inverse ShiftRows
//  in_state   in   32*NB     state; byte k = in_state[32*NB-1-8k -: 8]; row = k%4, col = k/4
//  in_tag     in   TAG_W     sideband, passed through unchanged
//  out_valid  out  1         output transaction present
//  out_ready  in   1         downstream accepts this cycle
//  out_state  out  32*NB     permuted state, same byte layout as in_state
//  out_tag    out  TAG_W     tag of the output transaction
//  occupancy  out  2         entries held: 0, 1 or 2
// BEHAVIOUR
//  - Row shifts s(r):
//    - s(0) = 0 for all NB.
//    - NB = 4 or 6: s(1..3) = 1, 2, 3.
//    - NB = 8: s(1..3) = 1, 3, 4.
//  - Forward: out[r][c] = in[r][(c + s(r)) mod NB].
//  - Inverse: out[r][c] = in[r][(c - s(r) + NB) mod NB].
//  - Both directions are pure byte moves; no arithmetic on byte values.
//  - Handshake:
//    - A transfer occurs on any cycle with valid & ready both high.
//    - in_valid, in_state and in_tag may change only after acceptance.
//    - out_valid, out_state and out_tag are held stable until out_ready is sampled high.
//  - Storage: the permutation is applied before registering, into the output register (OREG).
//    The skid register (SREG) holds one extra permuted entry.
//  - in_ready = !SREG.valid && !rst, driven directly from a register (no combinational path from out_ready).
//  - Latency: 1 cycle, input accept to out_valid, when the unit is empty.
//  - Throughput: 1 transaction/cycle while out_ready stays high.
//  - Per-cycle update, with acc = input accepted and pop = output taken:
//    - acc & !OREG.valid:          load OREG.
//    - acc & pop, SREG empty:      load OREG.
//    - acc & !pop & OREG.valid:    load SREG.
//    - pop & SREG.valid:           OREG <= SREG, and SREG is cleared unless acc.
//    - pop & !acc & !SREG.valid:   OREG.valid <= 0.
//  - Full (occupancy = 2): in_ready = 0, so no input is lost.
//  - Empty: out_valid = 0. out_state and out_tag then hold their last values and do not matter.
//  - Order: transactions leave in FIFO order, and each keeps its own mode. A forward/inverse
//    mix needs no bubble.
//  - Reset (including mid-operation) discards all entries within 1 cycle. After reset:
//    out_valid = 0, occupancy = 0, out_state = 0, out_tag = 0.
//    in_ready = 0 while rst is high and 1 on the first cycle after rst falls.
//  - Simultaneous accept and pop at occupancy 2 cannot occur, because in_ready = 0 when full.
// STRUCTURE
//  - aes_pkg holds:
//    - the shift_row_offset(nb, r) function;
//    - the byte_idx(r, c) function;
//    - the sr_mode_e enum {SR_FWD = 0, SR_INV = 1};
//    - the legal-NB check.
//  - Sub-module shift_rows_perm #(NB): combinational forward/inverse permutation, built with a
//    generate loop.
//  - The handshake and skid logic live in shift_rows_unit.
// TESTING
//  - NB=4, fwd, state 000102..0f
//    -> out 00050a0f04090e03080d02070c01060b after 1 cycle.
//  - NB=4, inv, state 000102..0f
//    -> out 000d0a0704010e0b0805020f0c090603.
//    - A fwd then inv round-trip returns the input.
//  - NB=8, fwd, byte k = k
//    -> row 1 shifted by 1, row 2 by 3, row 3 by 4.
//    - Check col 0 = 00,05,0e,13.
//    - A fwd+inv round-trip on 1000 random states with random modes is the identity.
//  - Back-pressure: out_ready=0 while 3 inputs are offered
//    -> 2 accepted, occupancy = 2, in_ready = 0, output stable.
//    - Releasing out_ready drains the outputs in order, with tags 1, 2.
//  - Streaming with out_ready=1 and alternating modes
//    -> 1 output/cycle, correct per-transaction mode, no bubbles.
//  - rst asserted at occupancy 2
//    -> next cycle out_valid = 0, occupancy = 0, outputs 0.
//    - in_ready = 1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES/Rijndael definitions: ShiftRows offsets, byte addressing and
// the per-transaction direction enum.
package aes_pkg;

   typedef enum logic {
      SR_FWD = 1'b0,
      SR_INV = 1'b1
   } sr_mode_e;

   // Rijndael row offsets: rows 2 and 3 shift one extra column for 8-column blocks.
   function automatic int shift_row_offset(input int nb, input int r);
      if (r == 0) begin
         return 0;
      end
      if (nb == 8 && r >= 2) begin
         return r + 1;
      end
      return r;
   endfunction

   // Column-major byte numbering, byte 0 in the most significant position.
   function automatic int byte_idx(input int r, input int c);
      return 4 * c + r;
   endfunction

   function automatic bit nb_is_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; every output byte
// is a 2:1 mux between its forward and inverse source bytes.
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] src_state,
   input  sr_mode_e         mode,
   output logic [32*NB-1:0] dst_state
);

   localparam int W = 32 * NB;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_row
         localparam int SHIFT = shift_row_offset(NB, gi);
         for (genvar gc = 0; gc < NB; gc++) begin : g_col
            localparam int DST     = byte_idx(gi, gc);
            localparam int FWD_SRC = byte_idx(gi, (gc + SHIFT) % NB);
            localparam int INV_SRC = byte_idx(gi, (gc - SHIFT + NB) % NB);
            assign dst_state[W-1-8*DST -: 8] = (mode == SR_INV) ?
                                               src_state[W-1-8*INV_SRC -: 8] :
                                               src_state[W-1-8*FWD_SRC -: 8];
         end
      end
   endgenerate

endmodule

// File: rtl/shift_rows_unit.sv
// Pipelined ShiftRows stage: permutes on the way in, then holds results in an
// output register plus one skid entry so in_ready never depends on out_ready.
module shift_rows_unit
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [32*NB-1:0] in_state,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [32*NB-1:0] out_state,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       occupancy
);

   localparam int W = 32 * NB;

   generate
      if (!nb_is_legal(NB)) begin : g_bad_nb
         $error("shift_rows_unit: NB must be 4, 6 or 8");
      end
   endgenerate

   logic [W-1:0]     perm_state;
   logic             acc;
   logic             pop;

   logic             oreg_valid_reg, oreg_valid_next;
   logic [W-1:0]     oreg_state_reg, oreg_state_next;
   logic [TAG_W-1:0] oreg_tag_reg, oreg_tag_next;
   logic             sreg_valid_reg, sreg_valid_next;
   logic [W-1:0]     sreg_state_reg, sreg_state_next;
   logic [TAG_W-1:0] sreg_tag_reg, sreg_tag_next;

   shift_rows_perm #(.NB(NB)) u_perm (
      .src_state (in_state),
      .mode      (sr_mode_e'(in_mode)),
      .dst_state (perm_state)
   );

   assign in_ready  = !sreg_valid_reg && !rst;
   assign acc       = in_valid && in_ready;
   assign pop       = oreg_valid_reg && out_ready;
   assign out_valid = oreg_valid_reg;
   assign out_state = oreg_state_reg;
   assign out_tag   = oreg_tag_reg;
   assign occupancy = {1'b0, oreg_valid_reg} + {1'b0, sreg_valid_reg};

   always_comb begin
      oreg_valid_next = oreg_valid_reg;
      oreg_state_next = oreg_state_reg;
      oreg_tag_next   = oreg_tag_reg;
      sreg_valid_next = sreg_valid_reg;
      sreg_state_next = sreg_state_reg;
      sreg_tag_next   = sreg_tag_reg;

      if (pop) begin
         if (sreg_valid_reg) begin
            // Skid entry moves forward; a new arrival refills the skid slot.
            oreg_state_next = sreg_state_reg;
            oreg_tag_next   = sreg_tag_reg;
            if (acc) begin
               sreg_state_next = perm_state;
               sreg_tag_next   = in_tag;
            end else begin
               sreg_valid_next = 1'b0;
            end
         end else if (acc) begin
            oreg_state_next = perm_state;
            oreg_tag_next   = in_tag;
         end else begin
            oreg_valid_next = 1'b0;
         end
      end else if (acc) begin
         if (!oreg_valid_reg) begin
            oreg_valid_next = 1'b1;
            oreg_state_next = perm_state;
            oreg_tag_next   = in_tag;
         end else begin
            sreg_valid_next = 1'b1;
            sreg_state_next = perm_state;
            sreg_tag_next   = in_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oreg_valid_reg <= 1'b0;
         oreg_state_reg <= '0;
         oreg_tag_reg   <= '0;
         sreg_valid_reg <= 1'b0;
         sreg_state_reg <= '0;
         sreg_tag_reg   <= '0;
      end else begin
         oreg_valid_reg <= oreg_valid_next;
         oreg_state_reg <= oreg_state_next;
         oreg_tag_reg   <= oreg_tag_next;
         sreg_valid_reg <= sreg_valid_next;
         sreg_state_reg <= sreg_state_next;
         sreg_tag_reg   <= sreg_tag_next;
      end
   end

endmodule
